// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants and types for the fetch sequencer: NOP encoding, FSM states, default vectors.
// No logic, no latency; no flow control.
// Holds the misalignment test used by pc_next_sel when MISALIGN_TRAP_EN is defined.
package pc_fetch_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0010;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next fetch-PC selection: trap vector, redirect target, sequential +4 or hold. MISALIGN_TRAP_EN enables the trap path.
// Combinational, zero latency.
// No flow control; 'advance' is the accepted-fetch strobe from the sequencer.
module pc_next_sel
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] pc_jmp,
  input  logic        advance,
  output logic [31:0] pc_next,
  output logic        trap_hit
);

  logic [31:0] jmp_aligned;

  always_comb begin
    jmp_aligned = pc_jmp & ~32'h3;
`ifdef MISALIGN_TRAP_EN
    trap_hit = redirect && misaligned(pc_jmp);
`else
    trap_hit = 1'b0;
`endif
    // Redirect beats the sequential increment even when the old fetch is granted.
    if (trap_hit) begin
      pc_next = TRAP_VEC;
    end else if (redirect) begin
      pc_next = jmp_aligned;
    end else if (advance) begin
      pc_next = pc + 32'd4;
    end else begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC sequencer: one outstanding imem request, output word register to decode, redirect with kill. MISALIGN_TRAP_EN adds a misaligned-target trap.
// Latency: gnt at N, rvalid at N+k -> instr_valid at N+k+1; peak one instruction per 2 cycles.
// Backpressure: no new request while the output register holds an unconsumed word; redirect always wins.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] PC_jmp,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        decode_ready,
  output logic        misalign_trap,
  output logic [31:0] trap_addr
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         kill;
  logic [31:0]  pc_next;
  logic         trap_hit;
  logic         fetch_fire;
  logic         resp_fire;
  logic         load_word;

  // Only ask for a new word when there is somewhere to put it.
  assign imem_req   = (state == ST_FETCH) && (!instr_valid || decode_ready);
  assign imem_addr  = pc;
  assign fetch_fire = imem_req && imem_gnt;
  assign resp_fire  = (state == ST_WAIT) && imem_rvalid;
  assign load_word  = resp_fire && !kill && !redirect;

  pc_next_sel #(
    .TRAP_VEC (TRAP_VEC)
  ) u_pc_next_sel (
    .pc       (pc),
    .redirect (redirect),
    .pc_jmp   (PC_jmp),
    .advance  (fetch_fire),
    .pc_next  (pc_next),
    .trap_hit (trap_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_RST;
      pc            <= RESET_PC;
      req_pc        <= '0;
      kill          <= 1'b0;
      instr_valid   <= 1'b0;
      instr         <= NOP_INSTR;
      instr_pc      <= '0;
      misalign_trap <= 1'b0;
      trap_addr     <= '0;
    end else begin
      pc            <= pc_next;
      misalign_trap <= trap_hit;
      if (trap_hit) begin
        trap_addr <= PC_jmp;
      end

      case (state)
        ST_RST: begin
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          // A redirect coinciding with the grant lets the old request go out but marks it dead.
          if (fetch_fire) begin
            state  <= ST_WAIT;
            req_pc <= pc;
            kill   <= redirect;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state <= ST_FETCH;
            kill  <= 1'b0;
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end
        default: begin
          state <= ST_RST;
        end
      endcase

      if (redirect) begin
        instr_valid <= 1'b0;
      end else if (load_word) begin
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        instr_pc    <= req_pc;
      end else if (decode_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, wrap/trap sequences, then random traffic against a transaction model.
module tb_pc_fetch_ctrl;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] T_TRAP_VEC = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] PC_jmp = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready = 1'b0;
  logic        misalign_trap;
  logic [31:0] trap_addr;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .RESET_PC (T_RESET_PC),
    .TRAP_VEC (T_TRAP_VEC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect      (redirect),
    .PC_jmp        (PC_jmp),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .decode_ready  (decode_ready),
    .misalign_trap (misalign_trap),
    .trap_addr     (trap_addr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Contents of the imaginary instruction memory.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic set_in(input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdy, input logic rdr, input logic [31:0] j);
    imem_gnt     = g;
    imem_rvalid  = rv;
    imem_rdata   = rd;
    decode_ready = rdy;
    redirect     = rdr;
    PC_jmp       = j;
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    #1;
    if (check) begin
      chk("rst_imem_req", imem_req, 32'd0);
      chk("rst_imem_addr", imem_addr, T_RESET_PC);
      chk("rst_instr_valid", instr_valid, 32'd0);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_misalign_trap", misalign_trap, 32'd0);
      chk("rst_trap_addr", trap_addr, 32'd0);
    end
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] jmp;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                              input logic rdy, input logic rdr, input logic [31:0] j,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] eip, input logic [31:0] ei);
    vec_t v;
    v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.redir = rdr; v.jmp = j;
    v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_ipc = eip; v.e_instr = ei;
    return v;
  endfunction

  localparam int NVEC = 25;
  vec_t tbl [NVEC];

  // Transaction model: expected fetch PC, one pending request record, the word held for decode.
  bit          m_started;
  logic [31:0] m_pc;
  bit          m_vld;
  logic [31:0] m_ipc;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  bit          m_pend_kill;
  int          m_wait;
  bit          m_trap;
  logic [31:0] m_trap_addr;

  task automatic model_reset();
    m_started = 0; m_pc = T_RESET_PC; m_vld = 0; m_ipc = '0;
    m_pend = 0; m_pend_addr = '0; m_pend_kill = 0; m_wait = 0;
    m_trap = 0; m_trap_addr = '0;
  endtask

  function automatic bit model_req();
    return m_started && !m_pend && (!m_vld || decode_ready);
  endfunction

  task automatic model_step();
    bit grant, resp, newword, trap;
    if (!rst_n) begin
      model_reset();
    end else begin
      grant   = model_req() && imem_gnt;
      resp    = m_pend && imem_rvalid;
      newword = resp && !m_pend_kill && !redirect;
      trap    = redirect && TRAP_EN && (PC_jmp[1:0] != 2'b00);
      if (redirect) m_vld = 0;
      else if (newword) begin m_vld = 1; m_ipc = m_pend_addr; end
      else if (decode_ready) m_vld = 0;
      if (resp) m_pend = 0;
      else if (m_pend) begin
        if (redirect) m_pend_kill = 1;
        if (m_wait > 0) m_wait--;
      end
      if (grant) begin
        m_pend = 1; m_pend_addr = m_pc; m_pend_kill = redirect;
        m_wait = int'($urandom_range(0, 3));
      end
      m_trap = trap;
      if (trap) m_trap_addr = PC_jmp;
      if (redirect) m_pc = trap ? T_TRAP_VEC : {PC_jmp[31:2], 2'b00};
      else if (grant) m_pc = m_pc + 32'd4;
      m_started = 1;
    end
  endtask

  initial begin
    logic [31:0] j;
    bit          er;

    tbl[0]  = mk(0,0,'0,1,0,'0,            0,32'h000,0,'0,'0);
    tbl[1]  = mk(1,0,'0,1,0,'0,            1,32'h000,0,'0,'0);
    tbl[2]  = mk(0,1,32'h1111_0001,1,0,'0, 0,32'h004,0,'0,'0);
    tbl[3]  = mk(1,0,'0,1,0,'0,            1,32'h004,1,32'h000,32'h1111_0001);
    tbl[4]  = mk(0,1,32'h1111_0002,1,0,'0, 0,32'h008,0,'0,'0);
    tbl[5]  = mk(1,0,'0,1,0,'0,            1,32'h008,1,32'h004,32'h1111_0002);
    tbl[6]  = mk(0,1,32'h1111_0003,1,0,'0, 0,32'h00C,0,'0,'0);
    for (int i = 7; i < 12; i++)
      tbl[i] = mk(1,0,'0,0,0,'0,           0,32'h00C,1,32'h008,32'h1111_0003);
    tbl[12] = mk(1,0,'0,1,0,'0,            1,32'h00C,1,32'h008,32'h1111_0003);
    tbl[13] = mk(0,0,'0,1,1,32'h100,       0,32'h010,0,'0,'0);
    tbl[14] = mk(0,0,'0,1,0,'0,            0,32'h100,0,'0,'0);
    tbl[15] = mk(0,0,'0,1,0,'0,            0,32'h100,0,'0,'0);
    tbl[16] = mk(0,1,32'hDEAD_DEAD,1,0,'0, 0,32'h100,0,'0,'0);
    tbl[17] = mk(1,0,'0,1,1,32'h200,       1,32'h100,0,'0,'0);
    tbl[18] = mk(0,1,32'h0BAD_0001,1,0,'0, 0,32'h200,0,'0,'0);
    tbl[19] = mk(1,0,'0,1,0,'0,            1,32'h200,0,'0,'0);
    tbl[20] = mk(0,1,32'h0BAD_0002,1,1,32'h300, 0,32'h204,0,'0,'0);
    tbl[21] = mk(1,0,'0,1,0,'0,            1,32'h300,0,'0,'0);
    tbl[22] = mk(0,1,32'h1111_0004,1,0,'0, 0,32'h304,0,'0,'0);
    tbl[23] = mk(0,0,'0,1,0,'0,            1,32'h304,1,32'h300,32'h1111_0004);
    tbl[24] = mk(0,0,'0,1,0,'0,            1,32'h304,0,'0,'0);

    do_reset(1'b1);
    for (int i = 0; i < NVEC; i++) begin
      set_in(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy, tbl[i].redir, tbl[i].jmp);
      #1;
      chk($sformatf("vec%0d_imem_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("vec%0d_imem_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_instr_valid", i), instr_valid, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk($sformatf("vec%0d_instr_pc", i), instr_pc, tbl[i].e_ipc);
        chk($sformatf("vec%0d_instr", i), instr, tbl[i].e_instr);
      end
      @(negedge clk);
    end

    // Address wrap at the top of the space.
    do_reset(1'b0);
    set_in(0, 0, '0, 1, 0, '0);
    @(negedge clk);
    set_in(0, 0, '0, 1, 1, 32'hFFFF_FFFC);
    @(negedge clk);
    set_in(1, 0, '0, 1, 0, '0);
    #1;
    chk("wrap_req_top", imem_req, 32'd1);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    set_in(0, 1, 32'hCAFE_F00D, 1, 0, '0);
    @(negedge clk);
    set_in(0, 0, '0, 1, 0, '0);
    #1;
    chk("wrap_req_next", imem_req, 32'd1);
    chk("wrap_addr_next", imem_addr, 32'h0000_0000);
    chk("wrap_instr_valid", instr_valid, 32'd1);
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", instr, 32'hCAFE_F00D);
    @(negedge clk);

    // Misaligned redirect target.
    set_in(0, 0, '0, 0, 1, 32'h0000_0102);
    @(negedge clk);
    set_in(0, 0, '0, 1, 0, '0);
    #1;
    chk("mis_trap_pulse", misalign_trap, TRAP_EN ? 32'd1 : 32'd0);
    chk("mis_trap_addr", trap_addr, TRAP_EN ? 32'h0000_0102 : 32'd0);
    chk("mis_req", imem_req, 32'd1);
    chk("mis_fetch_addr", imem_addr, TRAP_EN ? T_TRAP_VEC : 32'h0000_0100);
    chk("mis_instr_valid", instr_valid, 32'd0);
    @(negedge clk);
    set_in(0, 0, '0, 1, 0, '0);
    #1;
    chk("mis_trap_end", misalign_trap, 32'd0);
    chk("mis_trap_addr_held", trap_addr, TRAP_EN ? 32'h0000_0102 : 32'd0);

    // Random traffic against the transaction model.
    do_reset(1'b0);
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      j = $urandom;
      if ($urandom_range(0, 3) != 0) j[1:0] = 2'b00;
      set_in($urandom_range(0, 2) != 0,
             m_pend && (m_wait == 0),
             m_pend ? mem_word(m_pend_addr) : $urandom,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 11) == 0,
             j);
      #1;
      er = model_req();
      chk($sformatf("rnd%0d_imem_req", c), imem_req, er);
      if (er) chk($sformatf("rnd%0d_imem_addr", c), imem_addr, m_pc);
      chk($sformatf("rnd%0d_instr_valid", c), instr_valid, m_vld);
      if (m_vld) begin
        chk($sformatf("rnd%0d_instr_pc", c), instr_pc, m_ipc);
        chk($sformatf("rnd%0d_instr", c), instr, mem_word(m_ipc));
      end
      chk($sformatf("rnd%0d_misalign_trap", c), misalign_trap, m_trap);
      chk($sformatf("rnd%0d_trap_addr", c), trap_addr, m_trap_addr);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and instruction-fetch sequencer for the RISC-V core: owns the architectural fetch PC, issues one-outstanding requests to instruction memory, and hands fetched words to decode with a valid/ready handshake. It is the consumer of the jump-target path: a `redirect` pulse with `PC_jmp` (from `jmp_ctrl`, qualified by the ALU branch/jump decision) replaces the sequential PC and kills any fetch in flight.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `TRAP_VEC`, 32'h0000_0010, redirect address for a misaligned target (only with `MISALIGN_TRAP_EN`)

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `redirect`  in  1  single-cycle request to jump to `PC_jmp`
- `PC_jmp`  in  32  jump/branch target
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, word aligned
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid (≥1 cycle after gnt, in order)
- `imem_rdata`  in  32  instruction word
- `instr_valid`  out  1  instruction available to decode
- `instr`  out  32  instruction word
- `instr_pc`  out  32  address of `instr`
- `decode_ready`  in  1  decode accepts `instr` when high with `instr_valid`
- `misalign_trap`  out  1  one-cycle pulse: misaligned redirect target
- `trap_addr`  out  32  offending target, held until next trap

## Operation
- State `pc` (next address to fetch), `kill` flag, output register {`instr_valid`,`instr`,`instr_pc`}.
- FSM states: RST (reset cycle), FETCH (`imem_req`=1), WAIT (request accepted, awaiting rvalid).
- RST -> FETCH unconditionally on the first cycle with `rst_n`=1.
- FETCH: `imem_req` high only when output register is empty or being consumed this cycle (`decode_ready`); `imem_addr`=`pc`. On `imem_gnt`: `instr_pc_next`<=`pc`, `pc`<=`pc`+4 (mod 2^32, wraps FFFF_FFFC->0), -> WAIT.
- WAIT: on `imem_rvalid` with `kill`=0: load `instr`<=`imem_rdata`, `instr_pc`<=address of that request, `instr_valid`<=1; -> FETCH. With `kill`=1: drop data, clear `kill`, -> FETCH.
- Output handshake: `instr_valid` drops after `decode_ready` unless a new word loads the same cycle; `instr`/`instr_pc` stable while `instr_valid`&&!`decode_ready`.
- `redirect` has highest priority, any state:
  - `pc`<=target; `instr_valid`<=0 next cycle.
  - FETCH without gnt: `imem_addr` switches to new target next cycle (imem port allows address change before gnt).
  - FETCH with gnt same cycle: old request accepted -> WAIT with `kill`=1.
  - WAIT without rvalid: `kill`<=1. WAIT with rvalid same cycle: response dropped, `kill` stays 0, -> FETCH.
- Second redirect while `kill`=1: only `pc` updates.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=32'h0000_0013 (NOP), `instr_pc`=0, `misalign_trap`=0, `trap_addr`=0, `kill`=0.
- `imem_req` asserted in the first cycle after `rst_n` deasserts.
- Latency gnt at cycle N, rvalid at N+k -> `instr_valid` at N+k+1. Peak throughput one instruction per 2 cycles (gnt immediate, rvalid next cycle).
- `redirect` at cycle N -> `imem_req` with new target at N+1 (if not waiting on a killed response); first redirected `instr_valid` ≥ N+3.
- Reset mid-fetch: all state cleared; pending response after reset is ignored (imem is reset on the same `rst_n`).

## Configuration
- `MISALIGN_TRAP_EN` defined: redirect with `PC_jmp[1:0]`!=0 pulses `misalign_trap` the next cycle, `trap_addr`<=`PC_jmp`, `pc`<=`TRAP_VEC`; kill rules as for any redirect.
- Undefined: `pc`<={`PC_jmp[31:2]`,2'b00}; `misalign_trap` and `trap_addr` tied 0.

## Structure
- Shared package / `util.v`: NOP encoding 32'h0000_0013, FSM state encoding, default `RESET_PC`/`TRAP_VEC`.
- One natural sub-module: `pc_next_sel` (combinational: redirect/trap/sequential +4 selection, alignment handling).

## Test plan
- Reset release, gnt same cycle, rvalid next cycle, decode_ready=1 -> `instr_pc` sequence 0,4,8 with `instr_valid` every other cycle.
- decode_ready=0 for 5 cycles -> `instr`/`instr_pc` held, `imem_req`=0 until consumed.
- Redirect to 0x100 while in WAIT, rvalid 3 cycles later -> that data dropped, next `instr_pc`=0x100.
- Redirect to 0x200 same cycle as gnt -> killed response discarded, next fetch 0x200; redirect same cycle as rvalid -> word never presented.
- Fetch at 0xFFFF_FFFC -> next `imem_addr`=0x0000_0000.
- `MISALIGN_TRAP_EN`: redirect to 0x102 -> `misalign_trap` pulse, `trap_addr`=0x102, next fetch 0x10; without macro next fetch 0x100.
